// File: rtl/gpr_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_mp_if
//  Purpose  : Decode/writeback bundle for the multi-port register file.
//  Revision : 1.0 - initial release
// ============================================================================
interface gpr_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] r_addr0;
   logic [ADDR_W-1:0] r_addr1;
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;
   logic              busy0;
   logic              busy1;
   logic              we0_;
   logic              we1_;
   logic [ADDR_W-1:0] w_addr0;
   logic [ADDR_W-1:0] w_addr1;
   logic [DATA_W-1:0] w_data0;
   logic [DATA_W-1:0] w_data1;
   logic              rsv_;
   logic [ADDR_W-1:0] rsv_addr;
   logic              clr_req;
   logic              clr_busy;

   modport master (
      output r_addr0, r_addr1, we0_, we1_, w_addr0, w_addr1,
             w_data0, w_data1, rsv_, rsv_addr, clr_req,
      input  r_data0, r_data1, busy0, busy1, clr_busy
   );

   modport slave (
      input  r_addr0, r_addr1, we0_, we1_, w_addr0, w_addr1,
             w_data0, w_data1, rsv_, rsv_addr, clr_req,
      output r_data0, r_data1, busy0, busy1, clr_busy
   );
endinterface
`default_nettype wire

// File: rtl/gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_mp
//  Purpose  : Two-write/two-read register file with bypass, scoreboard and
//             sequential soft-clear engine.
//  Revision : 1.0 - initial release
// ============================================================================
module gpr_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int REG_NUM = 32,
   parameter int R0_ZERO = 1
) (
   input  logic       clk,
   input  logic       reset,
   gpr_mp_if.slave    bus
);

   localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(REG_NUM - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_nxt;

   logic [DATA_W-1:0] r_regs [REG_NUM];
   logic [REG_NUM-1:0] r_sb;

   logic w_clr_busy;
   logic w_we0;
   logic w_we1;
   logic w_rsv;

   // Address is backed by storage and is not the hardwired-zero register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      logic ok;
      ok = (32'(a) < REG_NUM);
      if ((R0_ZERO != 0) && (a == '0)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = '0;
      if (addr_ok(a)) begin
         if (w_we1 && (bus.w_addr1 == a)) begin
            d = bus.w_data1;
         end else if (w_we0 && (bus.w_addr0 == a)) begin
            d = bus.w_data0;
         end else begin
            d = r_regs[a];
         end
      end
      return d;
   endfunction

   function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
      logic b;
      b = 1'b0;
      if (addr_ok(a)) begin
         if ((w_we1 && (bus.w_addr1 == a)) || (w_we0 && (bus.w_addr0 == a))) begin
            b = 1'b0;
         end else begin
            b = r_sb[a];
         end
      end
      return b;
   endfunction

   assign w_clr_busy = (r_state == CLEAR);

   // Lanes and reservations are qualified once here; an invalid request is
   // indistinguishable from no request for the array, scoreboard and bypass.
   assign w_we0 = !bus.we0_ && !w_clr_busy && addr_ok(bus.w_addr0);
   assign w_we1 = !bus.we1_ && !w_clr_busy && addr_ok(bus.w_addr1);
   assign w_rsv = !bus.rsv_ && !w_clr_busy && addr_ok(bus.rsv_addr);

   always_comb begin
      bus.r_data0  = rd_data(bus.r_addr0);
      bus.r_data1  = rd_data(bus.r_addr1);
      bus.busy0    = rd_busy(bus.r_addr0);
      bus.busy1    = rd_busy(bus.r_addr1);
      bus.clr_busy = w_clr_busy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         IDLE: begin
            if (bus.clr_req) begin
               w_state_nxt = CLEAR;
               w_idx_nxt   = '0;
            end
         end
         CLEAR: begin
            if (r_idx == c_last_idx) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Lane 1 is written after lane 0 so it wins a collision; the reservation
   // is applied last so it wins over a same-cycle clear of its bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
         r_sb <= '0;
      end else if (w_clr_busy) begin
         r_regs[r_idx] <= '0;
         r_sb[r_idx]   <= 1'b0;
      end else begin
         if (w_we0) begin
            r_regs[bus.w_addr0] <= bus.w_data0;
            r_sb[bus.w_addr0]   <= 1'b0;
         end
         if (w_we1) begin
            r_regs[bus.w_addr1] <= bus.w_data1;
            r_sb[bus.w_addr1]   <= 1'b0;
         end
         if (w_rsv) begin
            r_sb[bus.rsv_addr] <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpr_mp
//  Purpose  : Self-checking bench for gpr_mp against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_mp;

   localparam int N = 32;

   logic clk;
   logic reset;

   gpr_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   gpr_mp #(
      .DATA_W (32),
      .ADDR_W (5),
      .REG_NUM(N),
      .R0_ZERO(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: contents, reservation bits, clear cycles remaining.
   logic [31:0] m_regs [N];
   logic        m_sb   [N];
   int          m_left;
   logic        s_clr_busy;

   typedef struct {
      logic        we0_;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1_;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        rsv_;
      logic [4:0]  ra;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic        e_b0;
      logic        e_b1;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_regs[i] = '0;
         m_sb[i]   = 1'b0;
      end
      m_left = 0;
   endtask

   function automatic logic lane_hits(input logic [4:0] a);
      return (m_left == 0) &&
             ((!bus.we0_ && bus.w_addr0 == a) || (!bus.we1_ && bus.w_addr1 == a));
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (m_left == 0 && !bus.we1_ && bus.w_addr1 == a) return bus.w_data1;
      if (m_left == 0 && !bus.we0_ && bus.w_addr0 == a) return bus.w_data0;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0 || lane_hits(a)) return 1'b0;
      return m_sb[a];
   endfunction

   task automatic model_update();
      if (m_left > 0) begin
         m_regs[N - m_left] = '0;
         m_sb[N - m_left]   = 1'b0;
         m_left--;
      end else begin
         if (!bus.we0_ && bus.w_addr0 != 0) begin
            m_regs[bus.w_addr0] = bus.w_data0;
            m_sb[bus.w_addr0]   = 1'b0;
         end
         if (!bus.we1_ && bus.w_addr1 != 0) begin
            m_regs[bus.w_addr1] = bus.w_data1;
            m_sb[bus.w_addr1]   = 1'b0;
         end
         if (!bus.rsv_ && bus.rsv_addr != 0) m_sb[bus.rsv_addr] = 1'b1;
         if (bus.clr_req) m_left = N;
      end
   endtask

   task automatic check_model();
      check("r_data0", bus.r_data0, exp_data(bus.r_addr0));
      check("r_data1", bus.r_data1, exp_data(bus.r_addr1));
      check("busy0", 32'(bus.busy0), 32'(exp_busy(bus.r_addr0)));
      check("busy1", 32'(bus.busy1), 32'(exp_busy(bus.r_addr1)));
      check("clr_busy", 32'(bus.clr_busy), 32'(m_left > 0));
      s_clr_busy = bus.clr_busy;
   endtask

   task automatic tick();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.we0_ = 1'b1; bus.we1_ = 1'b1; bus.rsv_ = 1'b1; bus.clr_req = 1'b0;
      bus.w_addr0 = '0; bus.w_addr1 = '0; bus.w_data0 = '0; bus.w_data1 = '0;
      bus.rsv_addr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vecs[0]  = '{1'b0, 5'd5, 32'hAAAA, 1'b0, 5'd5, 32'h5555, 1'b1, 5'd0, 5'd5, 5'd6, 32'h5555, 32'h0,    1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd5, 5'd0, 32'h5555, 32'h0,    1'b0, 1'b0};
      vecs[2]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b0, 5'd7, 5'd7, 5'd5, 32'h0,    32'h5555, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd7, 5'd7, 32'h0,    32'h0,    1'b1, 1'b1};
      vecs[4]  = '{1'b0, 5'd7, 32'h77,   1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd7, 5'd5, 32'h77,   32'h5555, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd7, 5'd7, 32'h77,   32'h77,   1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd9, 32'h99,   1'b1, 5'd0, 32'h0,    1'b0, 5'd9, 5'd9, 5'd9, 32'h99,   32'h99,   1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd9, 5'd7, 32'h99,   32'h77,   1'b1, 1'b0};
      vecs[8]  = '{1'b1, 5'd0, 32'h0,    1'b0, 5'd9, 32'h999,  1'b1, 5'd0, 5'd9, 5'd9, 32'h999,  32'h999,  1'b0, 1'b0};
      vecs[9]  = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd9, 5'd9, 32'h999,  32'h999,  1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd0, 32'h123,  1'b1, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0};
      vecs[11] = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd5, 32'h0,    32'h5555, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 5'd4, 32'h44,   1'b0, 5'd3, 32'h33,   1'b1, 5'd0, 5'd3, 5'd4, 32'h33,   32'h44,   1'b0, 1'b0};
      vecs[13] = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 5'd4, 5'd3, 32'h44,   32'h33,   1'b0, 1'b0};

      idle_inputs();
      bus.r_addr0 = 5'd5;
      bus.r_addr1 = 5'd6;
      model_reset();
      reset = 1'b1;
      #12;
      check("reset r_data0", bus.r_data0, 32'h0);
      check("reset busy0", 32'(bus.busy0), 32'h0);
      check("reset clr_busy", 32'(bus.clr_busy), 32'h0);
      reset = 1'b0;
      tick();

      // Directed table: collision, bypass, scoreboard set/clear, R0.
      for (int v = 0; v < 14; v++) begin
         bus.we0_ = vecs[v].we0_; bus.w_addr0 = vecs[v].wa0; bus.w_data0 = vecs[v].wd0;
         bus.we1_ = vecs[v].we1_; bus.w_addr1 = vecs[v].wa1; bus.w_data1 = vecs[v].wd1;
         bus.rsv_ = vecs[v].rsv_; bus.rsv_addr = vecs[v].ra;
         bus.r_addr0 = vecs[v].r0; bus.r_addr1 = vecs[v].r1;
         @(negedge clk);
         check($sformatf("vec%0d r_data0", v), bus.r_data0, vecs[v].e_d0);
         check($sformatf("vec%0d r_data1", v), bus.r_data1, vecs[v].e_d1);
         check($sformatf("vec%0d busy0", v), 32'(bus.busy0), 32'(vecs[v].e_b0));
         check($sformatf("vec%0d busy1", v), 32'(bus.busy1), 32'(vecs[v].e_b1));
         @(posedge clk);
         model_update();
         #1;
      end
      idle_inputs();

      // Fill every register with i+1, then read all back.
      for (int i = 0; i < N; i++) begin
         bus.we0_ = 1'b0; bus.w_addr0 = 5'(i); bus.w_data0 = 32'(i + 1);
         bus.r_addr0 = 5'(i); bus.r_addr1 = 5'((i + N - 1) % N);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < N; i++) begin
         bus.r_addr0 = 5'(i); bus.r_addr1 = 5'(i);
         @(negedge clk);
         check("fill readback", bus.r_data0, (i == 0) ? 32'h0 : 32'(i + 1));
         @(posedge clk);
         model_update();
         #1;
      end
      bus.rsv_ = 1'b0; bus.rsv_addr = 5'd11; tick();
      bus.rsv_addr = 5'd12; tick();
      bus.rsv_ = 1'b1;

      // Soft clear: count busy cycles; a lane-0 write mid-clear must vanish.
      bus.clr_req = 1'b1; bus.r_addr0 = 5'd3; bus.r_addr1 = 5'd12;
      tick();
      bus.clr_req = 1'b0;
      cnt = 0;
      for (int g = 0; g < 100; g++) begin
         if (cnt == 2) begin bus.we0_ = 1'b0; bus.w_addr0 = 5'd3; bus.w_data0 = 32'hDEAD; end
         else bus.we0_ = 1'b1;
         tick();
         if (!s_clr_busy) break;
         cnt++;
      end
      check("clr_busy length", 32'(cnt), 32'(N));
      idle_inputs();
      for (int i = 0; i < N; i++) begin
         bus.r_addr0 = 5'(i); bus.r_addr1 = 5'(N - 1 - i);
         @(negedge clk);
         check("post-clear data", bus.r_data0, 32'h0);
         check("post-clear busy", 32'(bus.busy1), 32'h0);
         @(posedge clk);
         model_update();
         #1;
      end

      // Reset in the middle of a clear.
      bus.we0_ = 1'b0; bus.w_addr0 = 5'd20; bus.w_data0 = 32'h2020; tick();
      idle_inputs();
      bus.r_addr0 = 5'd20;
      tick();
      bus.clr_req = 1'b1; tick();
      bus.clr_req = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      #1;
      reset = 1'b1;
      #1;
      check("rst-in-clear clr_busy", 32'(bus.clr_busy), 32'h0);
      check("rst-in-clear reg20", bus.r_data0, 32'h0);
      model_reset();
      #1;
      reset = 1'b0;
      bus.clr_req = 1'b1; tick();
      bus.clr_req = 1'b0; tick();
      check("clear restart", 32'(s_clr_busy), 32'h1);
      for (int g = 0; g < 100 && s_clr_busy; g++) tick();
      check("clear restart ended", 32'(s_clr_busy), 32'h0);

      // Randomized traffic against the model.
      for (int t = 0; t < 400; t++) begin
         bus.we0_ = 1'($urandom_range(0, 1)); bus.w_addr0 = 5'($urandom_range(0, N - 1));
         bus.w_data0 = $urandom;
         bus.we1_ = 1'($urandom_range(0, 1)); bus.w_addr1 = 5'($urandom_range(0, N - 1));
         bus.w_data1 = $urandom;
         bus.rsv_ = 1'($urandom_range(0, 1)); bus.rsv_addr = 5'($urandom_range(0, N - 1));
         bus.r_addr0 = 5'($urandom_range(0, N - 1)); bus.r_addr1 = 5'($urandom_range(0, N - 1));
         bus.clr_req = ($urandom_range(0, 63) == 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpr_mp.md
# gpr_mp

Parametrised multi-port general-purpose register file for the cpu core. It replaces the single-write `gpr` with two write ports that carry fixed priority, a same-cycle write-to-read bypass, and an optional hardwired-zero R0. It also holds a per-register scoreboard for decode-stage hazard checks and a sequential soft-clear engine. It sits between the decode stage (reads, reservations) and the writeback stage (two retire lanes).

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width
- `REG_NUM`, 32, number of registers; must be ≤ 2^ADDR_W
- `R0_ZERO`, 1, if 1 then register 0 reads 0 and cannot be written or reserved

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `r_addr0`, `r_addr1`  in  ADDR_W  read addresses
- `r_data0`, `r_data1`  out  DATA_W  read data, combinational with bypass
- `busy0`, `busy1`  out  1  scoreboard status of `r_addr0` / `r_addr1`
- `we0_`, `we1_`  in  1  write enables for lanes 0 and 1, active-low
- `w_addr0`, `w_addr1`  in  ADDR_W  write addresses
- `w_data0`, `w_data1`  in  DATA_W  write data
- `rsv_`  in  1  reserve request, active-low; sets the scoreboard bit at `rsv_addr`
- `rsv_addr`  in  ADDR_W  register to reserve
- `clr_req`  in  1  starts a soft clear of all registers and the scoreboard
- `clr_busy`  out  1  soft clear in progress

## Operation
- **Storage**
  - `REG_NUM` × `DATA_W` array plus `REG_NUM` scoreboard bits.
  - Addresses ≥ `REG_NUM` are ignored on every write or reserve path. Reads of those addresses return 0 and report busy 0.
- **Writes**
  - Each lane writes on the rising edge while its enable is 0.
  - If both lanes target the same address, lane 1 wins.
  - With `R0_ZERO=1`, writes to address 0 are dropped.
- **Reads (combinational)**
  - Priority order: a matching enabled lane-1 write, then a matching enabled lane-0 write, then the array.
  - With `R0_ZERO=1`, address 0 always reads 0.
- **Scoreboard**
  - `rsv_=0` sets `sb[rsv_addr]`.
  - An enabled write on either lane clears `sb[w_addr]`.
  - If a set and a clear hit the same address in the same cycle, the set wins.
  - `busyN = sb[r_addrN]`, forced to 0 when an enabled write to `r_addrN` is present that cycle (consistent with the bypass). A reservation affects `busyN` only from the next cycle.
- **Soft-clear FSM**, states `IDLE` and `CLEAR`, with index counter `idx` of ADDR_W bits:
  - `IDLE`: `clr_req=1` → `CLEAR` with `idx=0`.
  - `CLEAR`: each cycle writes 0 to `reg[idx]`, clears `sb[idx]`, and increments `idx`. After `idx=REG_NUM-1` the FSM returns to `IDLE`.
  - In `CLEAR`, both write lanes and `rsv_` are ignored. `clr_req` is ignored.
  - Reads stay live during `CLEAR`; the array is partially cleared. Bypass is suppressed while `clr_busy=1`.
  - `clr_busy = (state == CLEAR)`.

## Timing
- Reset (asynchronous, immediate) sets all registers to 0, all scoreboard bits to 0, state to `IDLE`, `idx` to 0 and `clr_busy` to 0. `r_data*` and `busy*` therefore read 0.
- Write latency: data is visible through the bypass in the same cycle and from the array after the next rising edge.
- Read latency: 0 cycles, combinational.
- Reserve latency: `busy` reads 1 starting one cycle after `rsv_=0`.
- Soft clear:
  - `clr_busy` rises the edge after `clr_req` is sampled and stays high for exactly `REG_NUM` cycles.
  - The first `IDLE` cycle after that accepts a new `clr_req`.
- Reset asserted during `CLEAR` aborts the clear immediately and zeroes all state, including registers not yet swept.

## Test plan
- **Reset.** Assert reset mid-cycle → within the same cycle `r_data0=r_data1=0`, `busy0=busy1=0`, `clr_busy=0`.
- **Fill and read.** For i=0..31, write i+1 on lane 0, then read i on both ports the next cycle → `r_data=i+1` for i≥1. Address 0 reads 0 with `R0_ZERO=1`.
- **Dual-write collision and bypass.** Lane 0 writes 5←0xAAAA and lane 1 writes 5←0x5555 in one cycle with `r_addr0=5` → `r_data0=0x5555` that cycle and 0x5555 from the array afterwards.
- **Scoreboard.**
  - `rsv_=0`, addr 7 → `busy0=1` (`r_addr0=7`) from the next cycle.
  - A lane-0 write to 7 → `busy0=0` in the same cycle, and stays 0.
  - Simultaneous reserve and write on addr 9 → `busy` for 9 is 1 the next cycle.
- **Soft clear.** With registers holding i+1, pulse `clr_req` → `clr_busy` is high for 32 cycles.
  - A write to 3 issued during the clear is dropped.
  - Afterwards all reads are 0 and all busy bits are 0.
- **Reset during clear.** Assert reset at clear cycle 10 → `clr_busy=0` at once. `reg[20]` reads 0 and a new `clr_req` is accepted.
